// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op encodings, FSM states, byte-lane selects
// and small alignment helpers (big-endian lane numbering).
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_LL   = 4'd9,
        OP_SC   = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H2 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] sel;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (off)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
            end
            OP_LH, OP_LHU, OP_SH:       sel = off[1] ? SEL_H2 : SEL_H0;
            OP_LW, OP_SW, OP_LL, OP_SC: sel = SEL_W;
            default:                    sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH:       mis = off[0];
            OP_LW, OP_SW, OP_LL, OP_SC: mis = (off != 2'b00);
            default:                    mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] sdata);
        logic [31:0] data;
        case (op)
            OP_SB:   data = {4{sdata[7:0]}};
            OP_SH:   data = {2{sdata[15:0]}};
            default: data = sdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Req/ack data bus between the MEM stage (master) and the data memory (slave).
interface mem_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a big-endian read word and
// sign- or zero-extends it according to the load op.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane pick and extension
    always_comb begin
        case (offset)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            default: byte_s = rdata[7:0];
        endcase
        half_s = offset[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            OP_LB:   value = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  value = {24'd0, byte_s};
            OP_LH:   value = {{16{half_s[15]}}, half_s};
            OP_LHU:  value = {16'd0, half_s};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: loads/stores/LL/SC over a req/ack bus, stalling while busy.
// Optional bus watchdog is compiled in with MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_we_hilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [5:0]  stall,
    input  logic        llbit,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_we_hilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_LLbit_we,
    output logic        mem_LLbit_value,
    output logic        stallreq,
    output logic        addr_err,
    mem_access_if.master bus
);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    state_e      state_r, state_nxt_s;
    logic [31:0] rbuf_r;
    logic [7:0]  cnt_r;
    logic        tout_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_sel_r;

    logic        is_load_s, is_store_s, is_sc_s, misalign_s, llbit_eff_s;
    logic        need_bus_s, timeout_s, tout_s, sc_ok_s;
    logic [31:0] load_val_s;
    logic        unused_stall_s;

    assign unused_stall_s = ^{stall[5], stall[3:0]};
    assign llbit_eff_s    = wb_LLbit_we ? wb_LLbit_value : llbit;
    assign misalign_s     = is_misaligned(ex_op, ex_addr[1:0]);
    assign need_bus_s     = !misalign_s && (is_load_s || is_store_s || (is_sc_s && llbit_eff_s));
    assign timeout_s      = TIMEOUT_EN && (state_r == ST_WAIT) && !bus.bus_ack && (cnt_r == TIMEOUT_LAST);
    assign tout_s         = tout_r && (state_r == ST_DONE);
    // Outside IDLE an SC is only present because it went to the bus, i.e. it succeeded
    assign sc_ok_s        = (state_r != ST_IDLE) || llbit_eff_s;

    assign bus.bus_req   = (state_r == ST_WAIT);
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_sel   = bus_sel_r;
    assign bus.bus_wdata = bus_wdata_r;
    assign bus.bus_err   = timeout_s;
    assign addr_err      = misalign_s;

    mem_load_align u_align (
        .rdata  (rbuf_r),
        .offset (ex_addr[1:0]),
        .op     (ex_op),
        .value  (load_val_s)
    );

    // Op class decode; unknown codes fall through as NONE
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        is_sc_s    = 1'b0;
        case (ex_op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: is_load_s  = 1'b1;
            OP_SB, OP_SH, OP_SW:                       is_store_s = 1'b1;
            OP_SC:                                     is_sc_s    = 1'b1;
            default:                                   is_load_s  = 1'b0;
        endcase
    end

    // Next-state logic and stall request
    always_comb begin
        state_nxt_s = state_r;
        stallreq    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (need_bus_s) begin
                    state_nxt_s = ST_WAIT;
                    stallreq    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                if (bus.bus_ack || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (!stall[4]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, read buffer and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            rbuf_r  <= 32'd0;
            cnt_r   <= 8'd0;
            tout_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_WAIT && bus.bus_ack) begin
                rbuf_r <= bus.bus_rdata;
                tout_r <= 1'b0;
            end else if (timeout_s) begin
                rbuf_r <= 32'd0;
                tout_r <= 1'b1;
            end else begin
                rbuf_r <= rbuf_r;
                tout_r <= tout_r;
            end
            if (TIMEOUT_EN && state_r == ST_WAIT && !bus.bus_ack) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'd0;
            end
        end
    end

    // Bus command is latched on entry to WAIT so it cannot move mid-transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_sel_r   <= 4'd0;
            bus_wdata_r <= 32'd0;
        end else if (state_r == ST_IDLE && need_bus_s) begin
            bus_we_r    <= is_store_s || is_sc_s;
            bus_addr_r  <= {ex_addr[31:2], 2'b00};
            bus_sel_r   <= lane_sel(ex_op, ex_addr[1:0]);
            bus_wdata_r <= store_lanes(ex_op, ex_sdata);
        end else begin
            bus_we_r    <= bus_we_r;
            bus_addr_r  <= bus_addr_r;
            bus_sel_r   <= bus_sel_r;
            bus_wdata_r <= bus_wdata_r;
        end
    end

    // Writeback fields toward MEM/WB
    always_comb begin
        mem_we          = ex_we;
        mem_waddr       = ex_waddr;
        mem_wdata       = ex_wdata;
        mem_we_hilo     = ex_we_hilo;
        mem_hi          = ex_hi;
        mem_lo          = ex_lo;
        mem_LLbit_we    = 1'b0;
        mem_LLbit_value = 1'b0;
        if (misalign_s) begin
            mem_we = 1'b0;
        end else if (tout_s) begin
            mem_we    = 1'b0;
            mem_wdata = 32'd0;
        end else if (is_load_s) begin
            mem_wdata       = load_val_s;
            mem_LLbit_we    = (ex_op == OP_LL);
            mem_LLbit_value = (ex_op == OP_LL);
        end else if (is_sc_s) begin
            mem_wdata    = {31'd0, sc_ok_s};
            mem_LLbit_we = sc_ok_s;
        end else begin
            mem_we = ex_we;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; the watchdog scenario is
// exercised only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk, rst;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr, ex_sdata, ex_wdata, ex_hi, ex_lo;
    logic        ex_we, ex_we_hilo;
    logic [4:0]  ex_waddr;
    logic [5:0]  stall;
    logic        llbit, wb_LLbit_we, wb_LLbit_value;
    logic        mem_we, mem_we_hilo, mem_LLbit_we, mem_LLbit_value, stallreq, addr_err;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    int          n_total, n_pass, n_fail;

    mem_access_if bus ();

    mem_access #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_op(ex_op), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_we_hilo(ex_we_hilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .stall(stall),
        .llbit(llbit), .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_we_hilo(mem_we_hilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
        .stallreq(stallreq), .addr_err(addr_err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        clk = 1'b0; rst = 1'b0;
        ex_op = OP_NONE; ex_addr = 32'd0; ex_sdata = 32'd0;
        ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hDEADBEEF;
        ex_we_hilo = 1'b1; ex_hi = 32'h11112222; ex_lo = 32'h33334444;
        stall = 6'd0; llbit = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        #3;
        chk("rst_bus_req", bus.bus_req, 32'd0);
        chk("rst_bus_err", bus.bus_err, 32'd0);
        chk("rst_stallreq", stallreq, 32'd0);
        chk("rst_pass_wdata", mem_wdata, 32'hDEADBEEF);
        chk("rst_pass_hi", mem_hi, 32'h11112222);
        step(); step();
        rst = 1'b1;

        // Unknown op code behaves as NONE
        ex_op = 4'd13; #1;
        chk("inv_stallreq", stallreq, 32'd0);
        chk("inv_wdata", mem_wdata, 32'hDEADBEEF);
        chk("inv_waddr", mem_waddr, 32'd7);
        chk("inv_lo", mem_lo, 32'h33334444);

        // LB at 0x1003, ack in first WAIT cycle
        step();
        ex_op = OP_LB; ex_addr = 32'h00001003; ex_waddr = 5'd3; ex_wdata = 32'h55; #1;
        chk("lb_stall_idle", stallreq, 32'd1);
        chk("lb_req_idle", bus.bus_req, 32'd0);
        step();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h112233F0; #1;
        chk("lb_req", bus.bus_req, 32'd1);
        chk("lb_sel", bus.bus_sel, 32'h1);
        chk("lb_addr", bus.bus_addr, 32'h00001000);
        chk("lb_bus_we", bus.bus_we, 32'd0);
        chk("lb_stall_wait", stallreq, 32'd1);
        step();
        bus.bus_ack = 1'b0; #1;
        chk("lb_stall_done", stallreq, 32'd0);
        chk("lb_wdata", mem_wdata, 32'hFFFFFFF0);
        chk("lb_mem_we", mem_we, 32'd1);
        chk("lb_req_done", bus.bus_req, 32'd0);
        step();

        // SH at 0x2002, ack in second WAIT cycle
        ex_op = OP_SH; ex_addr = 32'h00002002; ex_sdata = 32'h0000ABCD; #1;
        chk("sh_stall_idle", stallreq, 32'd1);
        step(); #1;
        chk("sh_sel", bus.bus_sel, 32'h3);
        chk("sh_bus_wdata", bus.bus_wdata, 32'hABCDABCD);
        chk("sh_bus_we", bus.bus_we, 32'd1);
        chk("sh_addr", bus.bus_addr, 32'h00002000);
        step();
        bus.bus_ack = 1'b1; #1;
        chk("sh_stall_wait2", stallreq, 32'd1);
        chk("sh_req_wait2", bus.bus_req, 32'd1);
        step();
        bus.bus_ack = 1'b0; #1;
        chk("sh_stall_done", stallreq, 32'd0);
        chk("sh_mem_we", mem_we, 32'd1);
        step();

        // Misaligned LW
        ex_op = OP_LW; ex_addr = 32'h00003001; #1;
        chk("lw_mis_addr_err", addr_err, 32'd1);
        chk("lw_mis_stall", stallreq, 32'd0);
        chk("lw_mis_mem_we", mem_we, 32'd0);
        chk("lw_mis_hilo", mem_we_hilo, 32'd1);
        step(); #1;
        chk("lw_mis_req", bus.bus_req, 32'd0);
        ex_op = OP_NONE; #1;
        chk("none_addr_err", addr_err, 32'd0);

        // LL
        step();
        ex_op = OP_LL; ex_addr = 32'h00004000; #1;
        chk("ll_stall", stallreq, 32'd1);
        step();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
        step();
        bus.bus_ack = 1'b0; #1;
        chk("ll_wdata", mem_wdata, 32'hCAFEF00D);
        chk("ll_llbit_we", mem_LLbit_we, 32'd1);
        chk("ll_llbit_val", mem_LLbit_value, 32'd1);
        step();

        // SC with forwarded LLbit=0 fails without a bus access
        ex_op = OP_SC; ex_sdata = 32'h12345678; llbit = 1'b1;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0; #1;
        chk("scf_stall", stallreq, 32'd0);
        chk("scf_wdata", mem_wdata, 32'd0);
        chk("scf_llbit_we", mem_LLbit_we, 32'd0);
        chk("scf_mem_we", mem_we, 32'd1);
        step(); #1;
        chk("scf_req", bus.bus_req, 32'd0);

        // SC with forwarded LLbit=1 stores
        wb_LLbit_value = 1'b1; #1;
        chk("scs_stall", stallreq, 32'd1);
        step();
        bus.bus_ack = 1'b1; #1;
        chk("scs_bus_we", bus.bus_we, 32'd1);
        chk("scs_bus_wdata", bus.bus_wdata, 32'h12345678);
        chk("scs_sel", bus.bus_sel, 32'hF);
        step();
        bus.bus_ack = 1'b0; #1;
        chk("scs_wdata", mem_wdata, 32'd1);
        chk("scs_llbit_we", mem_LLbit_we, 32'd1);
        chk("scs_llbit_val", mem_LLbit_value, 32'd0);
        step();
        wb_LLbit_we = 1'b0; llbit = 1'b0;

        // LW with stall[4] held three cycles in DONE; late acks ignored
        ex_op = OP_LW; ex_addr = 32'h00005004;
        step();
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BADBEEF; stall = 6'b010000;
        step();
        bus.bus_ack = 1'b0; #1;
        chk("hold_wdata_0", mem_wdata, 32'h0BADBEEF);
        chk("hold_stall_0", stallreq, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFFFFFF; #1;
            chk("hold_wdata", mem_wdata, 32'h0BADBEEF);
            chk("hold_stall", stallreq, 32'd0);
        end
        stall = 6'd0; bus.bus_ack = 1'b0;
        step(); #1;
        chk("hold_back_idle", stallreq, 32'd1);
        chk("hold_idle_req", bus.bus_req, 32'd0);
        ex_op = OP_NONE; #1;
        chk("hold_none_stall", stallreq, 32'd0);

        // Async reset in WAIT
        step();
        ex_op = OP_LW; ex_addr = 32'h00006000;
        step(); #1;
        chk("rw_req", bus.bus_req, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rw_req_async", bus.bus_req, 32'd0);
        chk("rw_stall_idle", stallreq, 32'd1);
        ex_op = OP_NONE; bus.bus_ack = 1'b1;
        step();
        rst = 1'b1;
        step(); #1;
        chk("rw_ack_ign_stall", stallreq, 32'd0);
        chk("rw_ack_ign_req", bus.bus_req, 32'd0);
        bus.bus_ack = 1'b0;

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Watchdog with BUS_TIMEOUT=4 and no ack
        ex_op = OP_LW; ex_addr = 32'h00007000; ex_we = 1'b1;
        step(); #1;
        chk("to_err_c1", bus.bus_err, 32'd0);
        step(); step(); #1;
        chk("to_err_c3", bus.bus_err, 32'd0);
        step(); #1;
        chk("to_err_c4", bus.bus_err, 32'd1);
        chk("to_stall_c4", stallreq, 32'd1);
        step(); #1;
        chk("to_err_done", bus.bus_err, 32'd0);
        chk("to_stall_done", stallreq, 32'd0);
        chk("to_mem_we", mem_we, 32'd0);
        step();
        ex_op = OP_NONE;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
